switch_debouncer: RTL
=====================

# switch_debouncer

Conditions a raw, asynchronous push-button or slide-switch level into a clean, single-clock-domain level for the D flip-flop stage directly downstream. It synchronises the input and requires it to hold a new value for a programmable number of consecutive cycles before accepting it, which rejects contact bounce. It also produces one-cycle rise/fall pulses. The cleaned level `d_out` drives the flip-flop's `d` input.

## Interface
- `STABLE_CYCLES`, default 4: consecutive synchronised cycles the new level must hold before it is accepted; legal range ≥ 2. Use large values in hardware (e.g. 1_000_000 at 100 MHz ≈ 10 ms).
- `CNT_W`, default `$clog2(STABLE_CYCLES)`: derived local width of the stability counter; not overridden.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: reset is synchronous and active-high.
- `d_raw` in 1: asynchronous raw switch level.
- `d_out` out 1: debounced level.
- `d_out_bar` out 1: always `~d_out`.
- `rise` out 1: one-cycle pulse when `d_out` goes 0→1.
- `fall` out 1: one-cycle pulse when `d_out` goes 1→0.
- `busy` out 1: high while a candidate change is being qualified.

## Operation
- `d_raw` passes through a two-flop synchroniser (`s1`, `s2`). Only `s2` is used by the logic.
- The state machine has four states:
  - `LOW_STABLE`: `d_out`=0. If `s2`=1, go to `WAIT_HIGH` and set cnt=1.
  - `WAIT_HIGH`: if `s2`=0, return to `LOW_STABLE` and set cnt=0 (glitch rejected). Else, if cnt==`STABLE_CYCLES`-1, go to `HIGH_STABLE`, set `d_out`=1, assert `rise`, and set cnt=0. Else increment cnt.
  - `HIGH_STABLE`: the mirror of `LOW_STABLE`, entering `WAIT_LOW` when `s2`=0.
  - `WAIT_LOW`: the mirror of `WAIT_HIGH`; asserts `fall` when it completes.
- `busy` = state is `WAIT_HIGH` or `WAIT_LOW`.
- The counter never exceeds `STABLE_CYCLES`-1. There is no wrap-around.
- `rise` and `fall` are never high together. Each is high for exactly one cycle per accepted transition.
- Reset behaviour (at any time, including mid-qualification):
  - `s1`=`s2`=0, cnt=0, state=`LOW_STABLE`.
  - `d_out`=0, `d_out_bar`=1, `rise`=`fall`=`busy`=0.
  - No pulse is generated on reset exit, even if `d_raw`=1. A `d_raw` held at 1 is qualified normally afterwards.

## Timing
- Edge k is the first rising edge that samples the new `d_raw` value into `s1`.
  - `s2` changes at edge k+1.
  - `busy` rises at edge k+2.
  - `d_out` and the pulse change at edge k+`STABLE_CYCLES`+1. With the default, that is edge k+5.
- A bounce is any `s2` return to the old level before acceptance. It restarts qualification from zero.
- Any pulse narrower than `STABLE_CYCLES` synchronised cycles never reaches `d_out`.
- All outputs are registered. There is no combinational path from `d_raw` to any output.

## Configuration
- Macro `SWITCH_DEBOUNCER_EDGES_EN`.
- Defined: `rise` and `fall` are generated as described above.
- Undefined: the pulse logic is omitted and `rise`/`fall` are tied to 0. The `d_out`, `d_out_bar` and `busy` timing is unchanged.

## Structure
- Package `switch_debouncer_pkg` holds:
  - `typedef enum logic [1:0] state_t`, with `LOW_STABLE`=0, `WAIT_HIGH`=1, `HIGH_STABLE`=2, `WAIT_LOW`=3.
  - Constant `MIN_STABLE_CYCLES`=2, checked by an elaboration-time assertion.
- One sub-module, `sync2`: the two-flop synchroniser with synchronous active-high reset, clearing to 0.

## Test plan
All scenarios use a 10 ns clock and `STABLE_CYCLES`=4.
- Reset: hold `rst`=1 for 2 cycles with `d_raw`=1 → `d_out`=0, `d_out_bar`=1, `rise`=`fall`=`busy`=0 throughout reset.
- Clean rise: `d_raw` 0→1 before edge k and held → `busy`=1 from edge k+2; `d_out`=1 and `rise`=1 for exactly one cycle at edge k+5.
- Bounce rejection: from stable low, `d_raw`=1 for 2 cycles, then 0 for 1 cycle, then 1 held → `d_out` stays 0 through the bounce. It rises 5 edges after the final 0→1 sample, with a single `rise` pulse.
- Clean fall: from stable high, `d_raw`=0 held → `d_out`=0 and `fall`=1 for one cycle 5 edges after sampling; `rise` stays 0.
- Reset mid-qualification: assert `rst` while in `WAIT_HIGH` with cnt=2 → the next edge gives state `LOW_STABLE`, cnt=0, `busy`=0, and no `rise`.
- Macro off: rerun the clean-rise scenario without `SWITCH_DEBOUNCER_EDGES_EN` → `d_out` timing is identical; `rise`/`fall` stay 0.

Source files
------------

// File: rtl/switch_debouncer_pkg.sv
// Shared types and limits for the switch debouncer.
package switch_debouncer_pkg;

  typedef enum logic [1:0] {
    LOW_STABLE  = 2'd0,
    WAIT_HIGH   = 2'd1,
    HIGH_STABLE = 2'd2,
    WAIT_LOW    = 2'd3
  } state_t;

  localparam int MIN_STABLE_CYCLES = 2;

endpackage

// File: rtl/switch_debouncer_sync2.sv
// Two-flop synchroniser for an asynchronous level; synchronous active-high reset clears to 0.
module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic s1_q, s1_d;
  logic s2_q, s2_d;

  always_comb begin
    s1_d = d;
    s2_d = s1_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/switch_debouncer.sv
// Switch debouncer: synchronise, qualify for STABLE_CYCLES samples, emit a clean level.
// Optional rise/fall pulses are built only when SWITCH_DEBOUNCER_EDGES_EN is defined.
module switch_debouncer
  import switch_debouncer_pkg::*;
#(
  parameter  int STABLE_CYCLES = 4,
  localparam int CNT_W         = $clog2(STABLE_CYCLES)
) (
  input  logic clk,
  input  logic rst,
  input  logic d_raw,
  output logic d_out,
  output logic d_out_bar,
  output logic rise,
  output logic fall,
  output logic busy
);

  if (STABLE_CYCLES < MIN_STABLE_CYCLES) begin : g_bad_cfg
    $fatal(1, "switch_debouncer: STABLE_CYCLES must be >= MIN_STABLE_CYCLES");
  end

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

  logic             s2;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             d_out_q, d_out_d;
  logic             busy_q, busy_d;
  logic             done;

  sync2 u_sync (
    .clk (clk),
    .rst (rst),
    .d   (d_raw),
    .q   (s2)
  );

  // A candidate is accepted on the sample that would push cnt past CNT_MAX.
  assign done = (cnt_q == CNT_MAX);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    d_out_d = d_out_q;
    case (state_q)
      LOW_STABLE: if (s2) begin
        state_d = WAIT_HIGH;
        cnt_d   = CNT_W'(1);
      end
      WAIT_HIGH: begin
        if (!s2) begin
          state_d = LOW_STABLE;
          cnt_d   = '0;
        end else if (done) begin
          state_d = HIGH_STABLE;
          d_out_d = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HIGH_STABLE: if (!s2) begin
        state_d = WAIT_LOW;
        cnt_d   = CNT_W'(1);
      end
      WAIT_LOW: begin
        if (s2) begin
          state_d = HIGH_STABLE;
          cnt_d   = '0;
        end else if (done) begin
          state_d = LOW_STABLE;
          d_out_d = 1'b0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = LOW_STABLE;
        cnt_d   = '0;
      end
    endcase
    busy_d = (state_d == WAIT_HIGH) || (state_d == WAIT_LOW);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LOW_STABLE;
      cnt_q   <= '0;
      d_out_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      d_out_q <= d_out_d;
      busy_q  <= busy_d;
    end
  end

  assign d_out     = d_out_q;
  assign d_out_bar = ~d_out_q;
  assign busy      = busy_q;

`ifdef SWITCH_DEBOUNCER_EDGES_EN
  logic rise_q, rise_d;
  logic fall_q, fall_d;

  always_comb begin
    rise_d = (state_q == WAIT_HIGH) &&  s2 && done;
    fall_d = (state_q == WAIT_LOW)  && !s2 && done;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign rise = rise_q;
  assign fall = fall_q;
`else
  assign rise = 1'b0;
  assign fall = 1'b0;
`endif

endmodule
